// File: rtl/btle_tx_framer_if.sv
// btle_tx_framer_if: PDU octet stream from the link layer into the transmit framer
interface btle_tx_framer_if;
    logic [7:0] octet_in;
    logic       octet_in_valid;
    logic       octet_in_ready;
    modport master (output octet_in, octet_in_valid, input octet_in_ready);
    modport slave (input octet_in, octet_in_valid, output octet_in_ready);
endinterface

// File: rtl/btle_tx_framer.sv
// btle_tx_framer: BLE 1 Mbps framer emitting preamble, access address, whitened PDU and CRC24 in air order
module btle_tx_framer #(
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CLK_PER_BIT              = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    input  logic                                start,
    btle_tx_framer_if.slave                     octet_bus,
    output logic                                info_bit,
    output logic                                bit_valid,
    output logic                                busy,
    output logic                                tx_end,
    output logic                                underrun
);
    localparam int AW = LEN_UNIQUE_BIT_SEQUENCE;
    localparam int RW = CRC_STATE_BIT_WIDTH;
    localparam int CW = $clog2(AW);
    localparam int DW = $clog2(CLK_PER_BIT);
    localparam logic [RW-1:0] POLY = RW'(24'h00065B);

    typedef enum logic [2:0] {IDLE, PREAMBLE, ACCESS_ADDR, PDU, CRC} state_t;

    state_t state, state_nxt;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic [AW-1:0] aa;
    logic [RW-1:0] crc;
    logic [6:0] w, w_nxt;
    logic [7:0] hold, sh, acc, sent, n;
    logic full, last_bit, tick, first, data, cur_bit, take;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

    always_comb begin
        busy = state != IDLE;
        tick = busy && div == '0;
        first = cnt[2:0] == 3'd0;
        data = first ? hold[0] : sh[0];
        w_nxt = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        state_nxt = state;
        cur_bit = last_bit;
        tx_end = 1'b0;
        underrun = 1'b0;
        case (state)
            IDLE: state_nxt = start ? PREAMBLE : IDLE;
            PREAMBLE: begin
                cur_bit = aa[0] ^ cnt[0];
                if (tick && cnt == CW'(7)) state_nxt = ACCESS_ADDR;
            end
            ACCESS_ADDR: begin
                cur_bit = aa[cnt];
                if (tick && cnt == CW'(AW - 1)) state_nxt = PDU;
            end
            PDU: begin
                cur_bit = data ^ w[6];
                underrun = tick && first && !full;
                tx_end = underrun;
                if (underrun) state_nxt = IDLE;
                else if (tick && cnt[2:0] == 3'd7 && sent + 8'd1 == n) state_nxt = CRC;
            end
            CRC: begin
                cur_bit = crc[RW-1] ^ w[6];
                tx_end = tick && cnt == CW'(RW - 1);
                if (tx_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bit_valid = tick && !underrun;
        info_bit = bit_valid ? cur_bit : last_bit;
        // the length octet (second one) unlocks the N limit; until then prefetch freely
        octet_bus.octet_in_ready = busy && !full && !tx_end && (acc < 8'd2 || acc < n);
        take = octet_bus.octet_in_valid && octet_bus.octet_in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            cnt <= '0;
            last_bit <= 1'b0;
            full <= 1'b0;
            acc <= '0;
            sent <= '0;
            n <= '0;
        end else begin
            last_bit <= info_bit;
            if (!busy) begin
                div <= '0;
                cnt <= '0;
                full <= 1'b0;
                acc <= '0;
                sent <= '0;
                n <= '0;
                if (start) begin
                    aa <= unique_bit_sequence;
                    crc <= crc_state_init_bit;
                    w <= {channel_number[0], channel_number[1], channel_number[2],
                          channel_number[3], channel_number[4], channel_number[5], 1'b1};
                end
            end else begin
                if (take) begin
                    hold <= octet_bus.octet_in;
                    full <= 1'b1;
                    acc <= acc + 8'd1;
                    if (acc == 8'd1) n <= 8'd2 + {1'b0, octet_bus.octet_in[6:0]};
                end
                div <= tick ? DW'(CLK_PER_BIT - 1) : div - DW'(1);
                if (tick) begin
                    cnt <= state_nxt != state ? '0 : cnt + CW'(1);
                    if (state == PDU && !underrun) begin
                        sh <= first ? {1'b0, hold[7:1]} : {1'b0, sh[7:1]};
                        if (first) full <= 1'b0;
                        if (cnt[2:0] == 3'd7) sent <= sent + 8'd1;
                        crc <= {crc[RW-2:0], 1'b0} ^ ((crc[RW-1] ^ data) ? POLY : '0);
                        w <= w_nxt;
                    end
                    if (state == CRC) begin
                        crc <= {crc[RW-2:0], 1'b0};
                        w <= w_nxt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_btle_tx_framer.sv
// tb_btle_tx_framer: randomized packets checked against a bit-level air-order model of the framer
module tb_btle_tx_framer;
    typedef logic [7:0] byte_t;
    typedef byte_t oq_t[$];
    typedef bit bq_t[$];

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] aa_in = '0;
    logic [5:0] ch_in = '0;
    logic [23:0] ci_in = '0;
    logic info_bit, bit_valid, busy, tx_end, underrun;

    btle_tx_framer_if bus();

    btle_tx_framer dut (
        .clk(clk), .rst(rst), .unique_bit_sequence(aa_in), .channel_number(ch_in),
        .crc_state_init_bit(ci_in), .start(start), .octet_bus(bus),
        .info_bit(info_bit), .bit_valid(bit_valid), .busy(busy), .tx_end(tx_end), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    bit bits[$];
    int bcyc[$];
    int n_end = 0, end_cyc = 0, hold_err = 0;
    bit end_ur = 1'b0, hs = 1'b0, last_b = 1'b0;

    always @(negedge clk) begin
        hs = bus.octet_in_valid && bus.octet_in_ready;
        if (bit_valid) begin
            bits.push_back(info_bit);
            bcyc.push_back(cyc);
            last_b = info_bit;
        end else if (busy && info_bit !== last_b) hold_err++;
        if (tx_end) begin
            n_end++;
            end_cyc = cyc;
            end_ur = underrun;
        end
    end

    byte_t feed_q[$];
    int feed_base = 0, feed_mode = 0, pkt_sc = 0, n_acc = 0, idx;

    // mode 0 offers every octet as early as possible; mode 1 only in the cycle before it is needed
    initial begin
        bus.octet_in_valid = 1'b0;
        bus.octet_in = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (hs) n_acc++;
            idx = n_acc - feed_base;
            bus.octet_in_valid = idx < feed_q.size() && (feed_mode == 0 || cyc == pkt_sc + 16 * (40 + 8 * idx));
            bus.octet_in = idx < feed_q.size() ? feed_q[idx] : 8'h00;
        end
    end

    function automatic bq_t model(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] ci, input oq_t o);
        bq_t q;
        int n;
        logic [23:0] c;
        logic [6:0] w;
        bit d;
        n = 2 + int'(o[1][6:0]);
        for (int k = 0; k < 8; k++) q.push_back(aa[0] ^ bit'(k % 2));
        for (int k = 0; k < 32; k++) q.push_back(aa[k]);
        c = ci;
        w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        for (int j = 0; j < n; j++)
            for (int b = 0; b < 8; b++) begin
                d = j < o.size() ? o[j][b] : 1'b0;
                q.push_back(d ^ w[6]);
                c = {c[22:0], 1'b0} ^ ((c[23] ^ d) ? 24'h00065B : 24'h0);
                w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
            end
        for (int k = 0; k < 24; k++) begin
            q.push_back(c[23-k] ^ w[6]);
            w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        end
        return q;
    endfunction

    function automatic oq_t mk(input int len, input int extra);
        oq_t q;
        q.push_back(8'($urandom));
        q.push_back({1'($urandom), 7'(len)});
        for (int i = 0; i < len + extra; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic run(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] ci, input oq_t o,
                       input int nfeed, input int mode, input bit poke, input int stop_at, input string tag);
        bq_t e;
        int n, lexp, te, sc, b0, e0, a0, h0, mism, terr, lim;
        bit ur;
        e = model(aa, ch, ci, o);
        n = 2 + int'(o[1][6:0]);
        ur = nfeed < n;
        lexp = ur ? 40 + 8 * nfeed : e.size();
        b0 = bits.size();
        e0 = n_end;
        a0 = n_acc;
        h0 = hold_err;
        feed_q.delete();
        for (int i = 0; i < nfeed; i++) feed_q.push_back(o[i]);
        feed_base = n_acc;
        feed_mode = mode;
        aa_in = aa;
        ch_in = ch;
        ci_in = ci;
        start = 1'b1;
        sc = cyc;
        pkt_sc = sc;
        te = sc + 1 + 16 * (ur ? lexp : lexp - 1);
        lim = 16 * (lexp + 2) + 20;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            #1;
            if (n_end > e0 || (stop_at >= 0 && bits.size() - b0 > stop_at)) break;
            start = poke && cyc <= te && (cyc == te || cyc % 53 == 0);
        end
        start = 1'b0;
        mism = 0;
        terr = 0;
        for (int k = b0; k < bits.size(); k++) begin
            if (k - b0 < e.size() && bits[k] != e[k-b0]) mism++;
            if (bcyc[k] != sc + 1 + 16 * (k - b0)) terr++;
        end
        check({tag, " bit_errors"}, mism, 0);
        check({tag, " timing_errors"}, terr, 0);
        check({tag, " hold_errors"}, hold_err - h0, 0);
        if (stop_at >= 0) begin
            check({tag, " bits_before_stop"}, bits.size() - b0, stop_at + 1);
            return;
        end
        check({tag, " tx_end_count"}, n_end - e0, 1);
        check({tag, " bit_count"}, bits.size() - b0, lexp);
        check({tag, " tx_end_cycle"}, end_cyc, te);
        check({tag, " underrun"}, end_ur, ur);
        check({tag, " accepted"}, n_acc - a0, ur ? nfeed : n);
        check({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        oq_t p;
        int pb, pb2, m, e0, len;
        logic [7:0] pre;
        logic [31:0] a;
        logic [31:0] raa;
        logic [5:0] rch;
        logic [23:0] rci;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset bit_valid", bit_valid, 0);
        check("reset tx_end", tx_end, 0);
        check("reset underrun", underrun, 0);
        check("reset info_bit", info_bit, 0);
        check("reset ready", bus.octet_in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        pb = bits.size();
        p.delete();
        p.push_back(8'h00);
        p.push_back(8'h00);
        run(32'h8E89BED6, 6'd37, 24'h555555, p, 2, 0, 0, -1, "zero_len");
        pre = '0;
        a = '0;
        for (int k = 0; k < 8; k++) pre[k] = pb + k < bits.size() ? bits[pb+k] : 1'b0;
        for (int k = 0; k < 32; k++) a[k] = pb + 8 + k < bits.size() ? bits[pb+8+k] : 1'b0;
        check("zero_len preamble", pre, 8'hAA);
        check("zero_len access_addr", a, 32'h8E89BED6);

        raa = $urandom;
        rch = 6'($urandom_range(0, 39));
        rci = 24'($urandom);
        p = mk(37, 1);
        pb = bits.size();
        run(raa, rch, rci, p, 40, 0, 0, -1, "len37_extra");
        pb2 = bits.size();
        run(raa, rch, rci, p, 39, 1, 0, -1, "backpressure");
        m = 0;
        for (int k = 0; k < 376; k++)
            if (pb2 + k >= bits.size() || bits[pb+k] != bits[pb2+k]) m++;
        check("backpressure same_stream", m, 0);

        run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(5, 0), 2, 0, 0, -1, "underrun");

        run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(3, 0), 5, 0, 1, -1, "start_pokes");
        run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(1, 0), 3, 0, 0, -1, "back_to_back");

        e0 = n_end;
        run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(37, 0), 39, 0, 0, 100, "reset_mid");
        rst = 1'b1;
        feed_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_mid busy", busy, 0);
        check("reset_mid bit_valid", bit_valid, 0);
        check("reset_mid tx_end", tx_end, 0);
        check("reset_mid underrun", underrun, 0);
        check("reset_mid info_bit", info_bit, 0);
        check("reset_mid ready", bus.octet_in_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        check("reset_mid no_tx_end", n_end - e0, 0);
        run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(12, 0), 14, 0, 0, -1, "after_reset");

        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(0, 24);
            run($urandom, 6'($urandom_range(0, 39)), 24'($urandom), mk(len, 0), len + 2,
                int'($urandom_range(0, 1)), 0, -1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btle_tx_framer.md
Name: btle_tx_framer

Overview:
- BLE 1 Mbps link-layer transmit framer, the transmit-side counterpart of btle_rx_core.
- Accepts PDU octets over a valid/ready stream.
- Emits a serial bit stream in air order: preamble, access address, whitened PDU, whitened CRC24.
- One bit every CLK_PER_BIT clocks (16 MHz clk gives 1 Mbps); the bit stream feeds the downstream GFSK modulator.

Parameters:
LEN_UNIQUE_BIT_SEQUENCE, 32, access address width
CHANNEL_NUMBER_BIT_WIDTH, 6, channel index width
CRC_STATE_BIT_WIDTH, 24, CRC LFSR width
CLK_PER_BIT, 16, clk cycles per transmitted bit (>=4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
unique_bit_sequence  in  32  access address; sent LSB first
channel_number  in  6  whitening seed
crc_state_init_bit  in  24  CRC LFSR init
start  in  1  one-cycle pulse; starts a packet when idle
octet_in  in  8  PDU octet; LSB sent first
octet_in_valid  in  1  octet_in valid
octet_in_ready  out  1  framer accepts octet this cycle
info_bit  out  1  current air bit
bit_valid  out  1  one-cycle strobe per bit
busy  out  1  packet in progress
tx_end  out  1  one-cycle pulse at packet end or abort
underrun  out  1  valid with tx_end; 1 = aborted on missing octet

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter and CLK_PER_BIT divider cleared.
- Reset mid-packet: packet abandoned, no tx_end.
- IDLE, start=1:
  - Latch unique_bit_sequence, channel_number, crc_state_init_bit.
  - busy=1 from the next cycle.
  - Divider restarts; first bit_valid occurs 1 cycle after start.
  - Bit k is strobed at start_cycle+1+k*CLK_PER_BIT.
- start while busy is ignored.
- info_bit holds the last bit value between strobes.
- State sequence: IDLE -> PREAMBLE(8 bits) -> ACCESS_ADDR(32) -> PDU(8*N) -> CRC(24) -> IDLE.
- PREAMBLE: bit k = AA[0] XOR (k&1). The last preamble bit therefore differs from the first AA bit.
- ACCESS_ADDR: AA[0] first through AA[31]; not whitened, not in CRC.
- PDU length:
  - N = 2 + (octet1[6:0]), where octet1 is the second accepted octet; N ranges 2..129.
  - octet1 bit 7 is ignored for length.
- Octet buffer:
  - One holding register plus a bit shift register.
  - octet_in_ready=1 when busy, the holding register is empty, and the accepted count < N.
  - Before octet1 is accepted, the N-limit is treated as unknown (ready allowed).
  - Transfer occurs on octet_in_valid & octet_in_ready.
  - Ready may assert from the cycle after start, so octets can be prefetched during preamble/AA.
- Underrun:
  - Condition: at the strobe of the first bit of PDU octet j, the holding register is empty.
  - Response: no bit_valid that cycle; tx_end=1 and underrun=1 that cycle; go to IDLE; busy=0 next cycle.
- CRC24:
  - State s = crc_state_init_bit, updated for each PDU bit b (pre-whitening).
  - Update: fb = s[23]^b; s = {s[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
  - CRC state transmitted s[23] first down to s[0].
- Whitening:
  - 7-bit LFSR w[6:0] with w[0]=1, w[1]=ch[5], w[2]=ch[4] … w[6]=ch[0].
  - Air bit = data ^ w[6].
  - After each whitened bit: w = {w[5], w[4], w[3]^w[6], w[2], w[1], w[0], w[6]}, i.e. x^7+x^4+1.
  - Applied to PDU and CRC bits only.
- Normal end: tx_end=1, underrun=0 in the cycle of the last CRC bit strobe; busy=0 next cycle.
- Extra octets offered after N accepted are never accepted (ready stays low).
- start in the same cycle as tx_end is ignored; a new start is accepted from the following cycle.

Test Plan:
- Zero-length packet: AA=0x8E89BED6, ch=37, crc_init=0x555555, octets 0x00,0x00 pre-offered.
  - Expect exactly 80 bit_valid pulses, 16 cycles apart.
  - First 8 bits 0,1,0,1,0,1,0,1; next 32 = AA LSB first.
  - PDU+CRC bits match the Python model; tx_end with underrun=0 on strobe 80.
- Payload length 37 (header 0x02,0x25 plus 37 random octets):
  - Expect 8+32+312+24=376 bits and 39 accepted octets.
  - An extra 40th octet is held valid but never accepted.
- Underrun: supply only octet0 and octet1 (len=5), then deassert valid.
  - At strobe of bit 56 (first bit of octet2): no bit_valid; tx_end=1, underrun=1; busy=0 next cycle.
- Backpressure: valid asserted only 1 cycle before each needed octet boundary.
  - Expect no underrun and a bit stream identical to the prefetched case.
- start pulses during busy: ignored; bit count and timing unchanged.
  - start in tx_end cycle is ignored; start on the next cycle begins a packet with first strobe 1 cycle later.
- Reset asserted at bit 100 of the 376-bit packet.
  - All outputs 0 next cycle, no tx_end.
  - A new packet then transmits correctly with fresh CRC and whitening seeds.
- Loopback: output bits fed through the GFSK modulator into btle_rx_core.
  - Expect hit_flag, payload_length 37, octets equal to input, crc_ok=1.
